// File: rtl/bus_deserializer.sv
// Serial-to-parallel receive stage: hunts for a sync word to find word alignment,
// then emits aligned words and drops lock after too many words without a sync.
module bus_deserializer #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                    LOCK_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    output logic                  sync_det,
    output logic                  locked,
    output logic                  lock_lost
);

    localparam int FW = $clog2(DATA_WIDTH + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [FW-1:0] FILL_MAX  = FW'(DATA_WIDTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(LOCK_TIMEOUT);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   sr_reg, sr_next;
    logic [BW-1:0]           bit_cnt_reg, bit_cnt_next;
    logic [FW-1:0]           fill_cnt_reg, fill_cnt_next;
    logic [GW-1:0]           gap_cnt_reg, gap_cnt_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    valid_reg, valid_next;
    logic                    sync_reg, sync_next;
    logic                    locked_reg, locked_next;
    logic                    lost_reg, lost_next;

    logic [DATA_WIDTH-1:0]   next_sr;
    logic                    window_full;
    logic                    word_done;
    logic                    sync_hit;
    logic [GW-1:0]           gap_inc;
    logic                    timeout;

    assign next_sr     = {sr_reg[DATA_WIDTH-2:0], serial_in};
    // The incoming bit completes a full window only once DATA_WIDTH-1 bits are already held,
    // so cleared register zeros can never masquerade as a sync word.
    assign window_full = (fill_cnt_reg >= FILL_LAST);
    assign word_done   = (bit_cnt_reg == BIT_LAST);
    assign sync_hit    = (next_sr == SYNC_PATTERN);
    assign gap_inc     = gap_cnt_reg + 1'b1;
    assign timeout     = (gap_inc == GAP_LIMIT);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= HUNT;
            sr_reg       <= '0;
            bit_cnt_reg  <= '0;
            fill_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            sync_reg     <= 1'b0;
            locked_reg   <= 1'b0;
            lost_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            bit_cnt_reg  <= bit_cnt_next;
            fill_cnt_reg <= fill_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            sync_reg     <= sync_next;
            locked_reg   <= locked_next;
            lost_reg     <= lost_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = HUNT;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (window_full && sync_hit)
                        state_next = LOCKED;
                end
                LOCKED: begin
                    if (word_done && !sync_hit && timeout)
                        state_next = HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        sr_next       = sr_reg;
        bit_cnt_next  = bit_cnt_reg;
        fill_cnt_next = fill_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        data_next     = data_reg;
        valid_next    = 1'b0;
        sync_next     = 1'b0;
        locked_next   = locked_reg;
        lost_next     = 1'b0;

        if (!enable) begin
            // Flush keeps the last word visible but forgets all alignment
            sr_next       = '0;
            bit_cnt_next  = '0;
            fill_cnt_next = '0;
            gap_cnt_next  = '0;
            locked_next   = 1'b0;
        end else begin
            sr_next = next_sr;
            case (state_reg)
                HUNT: begin
                    locked_next = 1'b0;
                    if (fill_cnt_reg != FILL_MAX)
                        fill_cnt_next = fill_cnt_reg + 1'b1;
                    if (window_full && sync_hit) begin
                        locked_next  = 1'b1;
                        sync_next    = 1'b1;
                        data_next    = next_sr;
                        bit_cnt_next = '0;
                        gap_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    bit_cnt_next = word_done ? '0 : bit_cnt_reg + 1'b1;
                    if (word_done) begin
                        data_next = next_sr;
                        if (sync_hit) begin
                            sync_next    = 1'b1;
                            gap_cnt_next = '0;
                        end else begin
                            valid_next = 1'b1;
                            if (timeout) begin
                                lost_next     = 1'b1;
                                locked_next   = 1'b0;
                                fill_cnt_next = '0;
                                gap_cnt_next  = '0;
                            end else begin
                                gap_cnt_next = gap_inc;
                            end
                        end
                    end
                end
                default: begin
                    locked_next = 1'b0;
                end
            endcase
        end
    end

    assign parallel_data = data_reg;
    assign data_valid    = valid_reg;
    assign sync_det      = sync_reg;
    assign locked        = locked_reg;
    assign lock_lost     = lost_reg;

endmodule

// File: tb/tb_bus_deserializer.sv
// Self-checking bench for bus_deserializer: directed scenarios plus randomized traffic,
// compared every cycle against a word-level reference model of the receiver.
module tb_bus_deserializer;

    localparam int             DW   = 8;
    localparam logic [DW-1:0]  SYNC = 8'hA5;
    localparam int             TO   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          serial_in;
    logic [DW-1:0] parallel_data;
    logic          data_valid, sync_det, locked, lock_lost;

    logic [DW-1:0] z_data;
    logic          z_valid, z_sync, z_locked, z_lost;

    int n_vec  = 0;
    int n_miss = 0;
    string phase = "init";

    // Reference model state
    logic [DW-1:0] m_win;
    int            m_fill;
    bit            m_lk;
    int            m_phase;
    int            m_gap;
    logic [DW-1:0] m_pd;
    bit            m_dv, m_sd, m_ll;

    bus_deserializer #(.DATA_WIDTH(DW), .SYNC_PATTERN(SYNC), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
        .parallel_data(parallel_data), .data_valid(data_valid), .sync_det(sync_det),
        .locked(locked), .lock_lost(lock_lost)
    );

    bus_deserializer #(.DATA_WIDTH(DW), .SYNC_PATTERN(8'h00), .LOCK_TIMEOUT(TO)) dut_zero (
        .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
        .parallel_data(z_data), .data_valid(z_valid), .sync_det(z_sync),
        .locked(z_locked), .lock_lost(z_lost)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_win = '0; m_fill = 0; m_lk = 0; m_phase = 0; m_gap = 0;
        m_pd = '0; m_dv = 0; m_sd = 0; m_ll = 0;
    endtask

    // One sampled bit: tracks alignment as "bits since lock" modulo the word width
    task automatic model_step(input logic en, input logic b);
        m_dv = 0; m_sd = 0; m_ll = 0;
        if (!en) begin
            m_win = '0; m_fill = 0; m_lk = 0; m_phase = 0; m_gap = 0;
            return;
        end
        m_win = {m_win[DW-2:0], b};
        if (!m_lk) begin
            m_fill++;
            if (m_fill >= DW && m_win == SYNC) begin
                m_lk = 1; m_sd = 1; m_pd = m_win; m_phase = 0; m_gap = 0;
            end
        end else begin
            m_phase++;
            if (m_phase == DW) begin
                m_phase = 0;
                m_pd = m_win;
                if (m_win == SYNC) begin
                    m_sd = 1; m_gap = 0;
                end else begin
                    m_dv = 1; m_gap++;
                    if (m_gap == TO) begin
                        m_ll = 1; m_lk = 0; m_fill = 0; m_gap = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [DW+3:0] obs, exp;
        obs = {parallel_data, data_valid, sync_det, locked, lock_lost};
        exp = {m_pd, m_dv, m_sd, m_lk, m_ll};
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed pd=%h dv,sd,lk,ll=%b%b%b%b required pd=%h dv,sd,lk,ll=%b%b%b%b",
                   phase, obs[DW+3:4], obs[3], obs[2], obs[1], obs[0],
                   exp[DW+3:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic apply_bit(input logic en, input logic b);
        enable = en;
        serial_in = b;
        @(posedge clk);
        model_step(en, b);
        #1;
        check_all();
    endtask

    task automatic send_byte(input logic [DW-1:0] v);
        for (int i = DW - 1; i >= 0; i--) apply_bit(1'b1, v[i]);
    endtask

    initial begin
        logic [DW-1:0] rb;
        int kind;
        rst = 1'b0; enable = 1'b0; serial_in = 1'b0;
        model_reset();

        phase = "reset";
        repeat (3) @(posedge clk);
        #1 check_all();
        #3 rst = 1'b1;

        phase = "idle";
        repeat (10) apply_bit(1'b0, 1'b0);

        phase = "aligned";
        send_byte(8'hA5);
        check_bit("aligned_sync_det", sync_det, 1'b1);
        check_bit("aligned_locked", locked, 1'b1);
        send_byte(8'h3C);
        check_bit("aligned_dv_3c", data_valid, 1'b1);
        send_byte(8'hC3);
        apply_bit(1'b0, 1'b0);

        phase = "offset";
        apply_bit(1'b1, 1'b1); apply_bit(1'b1, 1'b0); apply_bit(1'b1, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h7E);
        check_bit("offset_dv_7e", data_valid, 1'b1);
        apply_bit(1'b0, 1'b0);

        phase = "zero_prefix";
        for (int i = 0; i < DW - 1; i++) begin
            apply_bit(1'b1, 1'b0);
            check_bit("zero_prefix_no_sync", z_sync, 1'b0);
        end
        apply_bit(1'b1, 1'b0);
        check_bit("zero_prefix_full_sync", z_sync, 1'b1);
        apply_bit(1'b0, 1'b0);

        phase = "periodic";
        for (int r = 0; r < 3; r++) begin
            send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        end
        check_bit("periodic_still_locked", locked, 1'b1);

        phase = "timeout";
        send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check_bit("timeout_not_yet", lock_lost, 1'b0);
        send_byte(8'h04);
        check_bit("timeout_lock_lost", lock_lost, 1'b1);
        check_bit("timeout_locked_low", locked, 1'b0);
        check_bit("timeout_dv", data_valid, 1'b1);
        send_byte(8'hA5);
        check_bit("timeout_relock", sync_det, 1'b1);

        phase = "flush_mid";
        apply_bit(1'b0, 1'b0);
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) apply_bit(1'b1, 1'(i & 1));
        apply_bit(1'b0, 1'b0);
        check_bit("flush_unlocked", locked, 1'b0);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h42);

        phase = "async_rst";
        for (int i = 0; i < 3; i++) apply_bit(1'b1, 1'b1);
        rst = 1'b0;
        model_reset();
        #1 check_all();
        check_bit("async_rst_pd0", parallel_data[0] | parallel_data[2], 1'b0);
        #2 rst = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h99);

        phase = "random";
        for (int it = 0; it < 400; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 2) begin
                send_byte(SYNC);
            end else if (kind <= 7) begin
                rb = DW'($urandom_range(0, 255));
                send_byte(rb);
            end else if (kind == 8) begin
                repeat ($urandom_range(1, 7)) apply_bit(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                repeat ($urandom_range(1, 3)) apply_bit(1'b0, 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
